// File: rtl/pid_core_scheduler.sv
// pid_core_scheduler: round-robin scheduler sharing one PID core among NCH channels.
module pid_core_scheduler #(
   parameter int NCH     = 4,
   parameter int DW      = 8,
   parameter int TIMEOUT = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NCH-1:0]         req,
   input  logic [NCH*DW-1:0]      sp_in,
   input  logic [NCH*DW-1:0]      fb_in,
   output logic [NCH-1:0]         ack,
   output logic [NCH-1:0]         err,
   output logic [NCH*DW-1:0]      ctrl_out,
   output logic                   busy,
   output logic                   core_start,
   output logic [$clog2(NCH)-1:0] core_ch,
   output logic [DW-1:0]          core_setpoint,
   output logic [DW-1:0]          core_feedback,
   input  logic                   core_done,
   input  logic [DW-1:0]          core_result
);
   localparam int CW = $clog2(NCH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] WB    = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     last_q, last_d, ch_q, ch_d, gnt;
   logic [DW-1:0]     sp_q, sp_d, fb_q, fb_d;
   logic [TW-1:0]     cnt_q, cnt_d;
   logic [NCH-1:0]    ack_q, ack_d, err_q, err_d;
   logic [NCH*DW-1:0] ctrl_q, ctrl_d;
   logic              start_q, start_d, busy_q, busy_d, gnt_ok;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      ch_d    = ch_q;
      sp_d    = sp_q;
      fb_d    = fb_q;
      cnt_d   = '0;
      ack_d   = '0;
      err_d   = err_q;
      ctrl_d  = ctrl_q;
      start_d = 1'b0;
      gnt_ok  = 1'b0;
      gnt     = '0;
      // search starts just past the last grant and wraps
      for (int i = 1; i <= NCH; i++) begin
         if (!gnt_ok && req[(int'(last_q) + i) % NCH]) begin
            gnt_ok = 1'b1;
            gnt    = CW'((int'(last_q) + i) % NCH);
         end
      end
      case (state_q)
         IDLE: if (gnt_ok) begin
            state_d = ISSUE;
            ch_d    = gnt;
            sp_d    = sp_in[int'(gnt)*DW +: DW];
            fb_d    = fb_in[int'(gnt)*DW +: DW];
            start_d = 1'b1;
         end
         ISSUE: state_d = WAIT;
         WAIT: if (core_done) begin
            ctrl_d[int'(ch_q)*DW +: DW] = core_result;
            err_d[ch_q] = 1'b0;
            ack_d[ch_q] = 1'b1;
            state_d     = WB;
         end else if (cnt_q == TW'(TIMEOUT - 1)) begin
            err_d[ch_q] = 1'b1;
            ack_d[ch_q] = 1'b1;
            state_d     = WB;
         end else begin
            cnt_d = cnt_q + TW'(1);
         end
         default: begin
            state_d = IDLE;
            last_d  = ch_q;
         end
      endcase
      busy_d = state_d != IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= CW'(NCH - 1);
         ch_q    <= '0;
         sp_q    <= '0;
         fb_q    <= '0;
         cnt_q   <= '0;
         ack_q   <= '0;
         err_q   <= '0;
         ctrl_q  <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         ch_q    <= ch_d;
         sp_q    <= sp_d;
         fb_q    <= fb_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         ctrl_q  <= ctrl_d;
         start_q <= start_d;
         busy_q  <= busy_d;
      end
   end

   assign ack           = ack_q;
   assign err           = err_q;
   assign ctrl_out      = ctrl_q;
   assign busy          = busy_q;
   assign core_start    = start_q;
   assign core_ch       = ch_q;
   assign core_setpoint = sp_q;
   assign core_feedback = fb_q;
endmodule

// File: tb/tb_pid_core_scheduler.sv
// tb_pid_core_scheduler: directed job table plus latency, timeout and reset-abort sequences.
module tb_pid_core_scheduler;
   localparam int NCH = 4;
   localparam int DW  = 8;
   localparam int TO  = 32;

   logic           clk, rst, busy, core_start, core_done;
   logic [NCH-1:0] req, ack, err;
   logic [31:0]    sp_in, fb_in, ctrl_out, sp_base, fb_base;
   logic [1:0]     core_ch;
   logic [7:0]     core_setpoint, core_feedback, core_result;
   logic [7:0]     exp_ctrl [NCH];
   logic [3:0]     exp_err;
   int             errs = 0;
   int             checks = 0;

   typedef struct {
      logic [3:0] set;
      int         dly;
      logic [7:0] res;
      int         ch;
   } vec_t;
   vec_t tbl [11];

   pid_core_scheduler #(.NCH(NCH), .DW(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .sp_in(sp_in), .fb_in(fb_in),
      .ack(ack), .err(err), .ctrl_out(ctrl_out), .busy(busy),
      .core_start(core_start), .core_ch(core_ch),
      .core_setpoint(core_setpoint), .core_feedback(core_feedback),
      .core_done(core_done), .core_result(core_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_pack();
      logic [31:0] r;
      for (int c = 0; c < NCH; c++) r[c*8 +: 8] = exp_ctrl[c];
      return r;
   endfunction

   always @(negedge clk) if (!rst && ack != 0) chk("ack_onehot", 64'($countones(ack)), 64'd1);

   task automatic run(input vec_t v);
      bit got;
      int n;
      req = req | v.set;
      got = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k == 0) chk("ack_single_cycle", 64'(ack), 64'd0);
         if (core_start) begin
            got = 1;
            break;
         end
      end
      chk("start_seen", 64'(got), 64'd1);
      if (!got) return;
      chk("core_ch", 64'(core_ch), 64'(v.ch));
      chk("core_setpoint", 64'(core_setpoint), 64'(8'(16*v.ch + 3)));
      chk("core_feedback", 64'(core_feedback), 64'(8'(16*v.ch + 5)));
      chk("busy_job", 64'(busy), 64'd1);
      sp_in = ~sp_base;
      fb_in = ~fb_base;
      got = 0;
      n = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         core_done = 1'b0;
         if (ack != 0) begin
            got = 1;
            n = k;
            break;
         end
         if (k == v.dly) begin
            core_done   = 1'b1;
            core_result = v.res;
         end
      end
      chk("ack_seen", 64'(got), 64'd1);
      chk("ack_value", 64'(ack), 64'(4'b0001 << v.ch));
      chk("ack_latency", 64'(n), 64'((v.dly != 0 && v.dly <= TO) ? v.dly + 1 : TO + 1));
      chk("setpoint_stable", 64'(core_setpoint), 64'(8'(16*v.ch + 3)));
      if (v.dly != 0 && v.dly <= TO) begin
         exp_ctrl[v.ch] = v.res;
         exp_err[v.ch]  = 1'b0;
      end else begin
         exp_err[v.ch]  = 1'b1;
      end
      chk("ctrl_out", 64'(ctrl_out), 64'(exp_pack()));
      chk("err", 64'(err), 64'(exp_err));
      req[v.ch] = 1'b0;
      sp_in = sp_base;
      fb_in = fb_base;
   endtask

   initial begin
      int starts, scyc, acyc, nack;
      bit got;
      logic [7:0] cap_sp, cap_fb;
      logic [1:0] cap_ch;
      tbl = '{
         '{4'b1111, 1,  8'h11, 0},
         '{4'b0000, 2,  8'h22, 1},
         '{4'b0001, 3,  8'h33, 2},
         '{4'b0000, 1,  8'h44, 3},
         '{4'b0000, 1,  8'h55, 0},
         '{4'b0010, 2,  8'h66, 1},
         '{4'b1001, 1,  8'h77, 3},
         '{4'b0000, 2,  8'h88, 0},
         '{4'b0010, 0,  8'h99, 1},
         '{4'b0010, 1,  8'h4d, 1},
         '{4'b0100, 32, 8'h5a, 2}
      };
      for (int c = 0; c < NCH; c++) begin
         sp_base[c*8 +: 8] = 8'(16*c + 3);
         fb_base[c*8 +: 8] = 8'(16*c + 5);
         exp_ctrl[c] = 8'h00;
      end
      exp_err = '0;
      sp_in = sp_base;
      fb_in = fb_base;
      rst = 1'b1;
      req = '0;
      core_done = 1'b0;
      core_result = '0;
      repeat (2) @(negedge clk);
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_ctrl", 64'(ctrl_out), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_start", 64'(core_start), 64'd0);
      chk("rst_ch", 64'(core_ch), 64'd0);
      chk("rst_sp_fb", 64'({core_setpoint, core_feedback}), 64'd0);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("idle_busy", 64'(busy), 64'd0);
      end
      foreach (tbl[i]) run(tbl[i]);

      // single ch2 job: start one cycle and ack five cycles after req is sampled
      repeat (2) @(negedge clk);
      sp_in[16 +: 8] = 8'd100;
      fb_in[16 +: 8] = 8'd60;
      req = 4'b0100;
      starts = 0; scyc = 0; acyc = 0; nack = 0;
      cap_sp = '0; cap_fb = '0; cap_ch = '0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (ack != 0) begin
            nack++;
            acyc = k;
            req = '0;
         end
         if (core_start) begin
            starts++;
            scyc = k;
            cap_ch = core_ch;
            cap_sp = core_setpoint;
            cap_fb = core_feedback;
         end
         core_done   = (starts == 1 && k == scyc + 3);
         core_result = 8'd80;
      end
      chk("lat_starts", 64'(starts), 64'd1);
      chk("lat_start_cycle", 64'(scyc), 64'd1);
      chk("lat_ack_cycle", 64'(acyc), 64'd5);
      chk("lat_ack_count", 64'(nack), 64'd1);
      chk("lat_ch_sp_fb", 64'({cap_ch, cap_sp, cap_fb}), 64'({2'd2, 8'd100, 8'd60}));
      exp_ctrl[2] = 8'd80;
      chk("lat_ctrl", 64'(ctrl_out), 64'(exp_pack()));
      sp_in = sp_base;
      fb_in = fb_base;

      // reset while waiting on the core aborts the job without an ack
      @(negedge clk);
      req = 4'b1000;
      got = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (core_start) begin
            got = 1;
            break;
         end
      end
      chk("abort_start_seen", 64'(got), 64'd1);
      @(negedge clk);
      chk("abort_busy_wait", 64'(busy), 64'd1);
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      rst = 1'b0;
      core_done = 1'b1;
      core_result = 8'hc3;
      chk("abort_busy", 64'(busy), 64'd0);
      @(negedge clk);
      core_done = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("abort_no_ack", 64'({busy, ack}), 64'd0);
         @(negedge clk);
      end
      chk("abort_ctrl", 64'(ctrl_out), 64'd0);
      chk("abort_err", 64'(err), 64'd0);
      chk("abort_start", 64'(core_start), 64'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
